// File: rtl/dbg_pc_trace_pkg.sv
// rtl/dbg_pc_trace_pkg.sv - shared types, widths and field slices for the PC trace buffer
package dbg_pc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trc_state_e;

  localparam int PC_W    = 18;
  localparam int STAMP_W = 18;
  localparam int DATA_W  = STAMP_W + PC_W;

  // rdDATA[0:17] (stamp) lives in the upper half, rdDATA[18:35] (PC) in the lower half
  localparam int PC_LSB    = 0;
  localparam int STAMP_LSB = PC_W;

  localparam logic [STAMP_W-1:0] STAMP_MAX = 18'o777777;

  function automatic int trc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/dbg_pc_trace_if.sv
// rtl/dbg_pc_trace_if.sv - console read bus and trace status between console and trace buffer
interface dbg_pc_trace_if #(
  parameter int ADDR_W = 4
);
  import dbg_pc_trace_pkg::*;

  logic              rdREQ;
  logic              rdACK;
  logic [DATA_W-1:0] rdDATA;
  logic [ADDR_W:0]   trcCOUNT;
  logic [1:0]        trcSTATE;

  modport master (output rdREQ, input rdACK, rdDATA, trcCOUNT, trcSTATE);
  modport slave  (input rdREQ, output rdACK, rdDATA, trcCOUNT, trcSTATE);

endinterface

// File: rtl/dbg_trace_ram.sv
// rtl/dbg_trace_ram.sv - DEPTH x DATA_W history RAM, synchronous write, asynchronous read
module dbg_trace_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dbg_pc_trace.sv
// rtl/dbg_pc_trace.sv - PC history trace buffer with breakpoint trigger and post-trigger fill
// Optional DBG_TRACE_STAMP_EN stores an 18-bit saturating clken-cycle stamp with each PC.
module dbg_pc_trace
  import dbg_pc_trace_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int POST_CNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clken,
  input  logic            loadIR,
  input  logic [PC_W-1:0] pcIN,
  input  logic            cpuHALT,
  input  logic            trcARM,
  input  logic            trcCLR,
  input  logic            brkEN,
  input  logic [PC_W-1:0] brkADDR,
  dbg_pc_trace_if.slave   con
);

  localparam int DEPTH = trc_depth(ADDR_W);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_INI = ADDR_W'(POST_CNT);

  trc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d, post_q, post_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rdack_q, rdack_d;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we;
  logic              halt, cap, hit;
  logic [STAMP_W-1:0] stamp;

`ifdef DBG_TRACE_STAMP_EN
  logic [STAMP_W-1:0] stamp_q, stamp_d;

  always_comb begin
    stamp_d = stamp_q;
    if (trcCLR || trcARM)                    stamp_d = '0;
    else if (clken && stamp_q != STAMP_MAX)  stamp_d = stamp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stamp_q <= '0;
    else      stamp_q <= stamp_d;
  end

  assign stamp = stamp_q;
`else
  assign stamp = '0;
`endif

  assign halt      = clken & cpuHALT;
  assign cap       = clken & loadIR & (state_q == ST_ARMED || state_q == ST_POST);
  assign hit       = brkEN & (pcIN == brkADDR);
  assign ram_wdata = {stamp, pcIN};

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    post_d   = post_q;
    rdack_d  = 1'b0;
    rddata_d = rddata_q;
    ram_we   = 1'b0;

    if (trcCLR || trcARM) begin
      state_d = trcCLR ? ST_IDLE : ST_ARMED;
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      post_d  = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (halt) begin
            state_d = ST_FROZEN;
          end else if (cap) begin
            ram_we = 1'b1;
            if (hit) begin
              if (POST_CNT == 0) state_d = ST_FROZEN;
              else begin
                state_d = ST_POST;
                post_d  = POST_INI;
              end
            end
          end
        end
        ST_POST: begin
          // A match here is deliberately ignored: one trigger per arm
          if (cap) begin
            ram_we = 1'b1;
            post_d = post_q - 1'b1;
            if (post_q == ADDR_W'(1)) state_d = ST_FROZEN;
          end
          if (halt) state_d = ST_FROZEN;
        end
        default: begin
          if (con.rdREQ) begin
            rdack_d = 1'b1;
            if (count_q != '0) begin
              rddata_d = ram_rdata;
              rp_d     = rp_q + 1'b1;
              count_d  = count_q - 1'b1;
            end else begin
              rddata_d = '0;
            end
          end
        end
      endcase

      // Full buffer: the write lands on the oldest entry, so the read pointer steps past it
      if (ram_we) begin
        wp_d = wp_q + 1'b1;
        if (count_q == FULL_CNT) rp_d = rp_q + 1'b1;
        else                     count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      post_q   <= '0;
      rdack_q  <= 1'b0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      post_q   <= post_d;
      rdack_q  <= rdack_d;
      rddata_q <= rddata_d;
    end
  end

  dbg_trace_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wp_q),
    .wdata (ram_wdata),
    .raddr (rp_q),
    .rdata (ram_rdata)
  );

  assign con.rdACK    = rdack_q;
  assign con.rdDATA   = rddata_q;
  assign con.trcCOUNT = count_q;
  assign con.trcSTATE = state_q;

endmodule

// File: tb/tb_dbg_pc_trace.sv
// tb/tb_dbg_pc_trace.sv - scoreboard bench for dbg_pc_trace (ADDR_W=4, POST_CNT=4)
module tb_dbg_pc_trace;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clken = 1'b1;
  logic        loadIR = 1'b0;
  logic [17:0] pcIN = '0;
  logic        cpuHALT = 1'b0;
  logic        trcARM = 1'b0;
  logic        trcCLR = 1'b0;
  logic        brkEN = 1'b0;
  logic [17:0] brkADDR = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  logic [35:0] rd_hist[$];

  dbg_pc_trace_if #(.ADDR_W(4)) con ();

  dbg_pc_trace #(.ADDR_W(4), .POST_CNT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .loadIR  (loadIR),
    .pcIN    (pcIN),
    .cpuHALT (cpuHALT),
    .trcARM  (trcARM),
    .trcCLR  (trcCLR),
    .brkEN   (brkEN),
    .brkADDR (brkADDR),
    .con     (con.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %o expected %o", name, act, exp);
    end
  endtask

  // Monitor: every acknowledged read is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst && con.rdACK) begin
      rd_hist.push_back(con.rdDATA);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got data %o expected no ack", con.rdDATA);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
`ifdef DBG_TRACE_STAMP_EN
        check("rd_pc", {18'b0, con.rdDATA[17:0]}, {18'b0, e[17:0]});
`else
        check("rd_data", con.rdDATA, e);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [17:0] pc);
    loadIR = 1'b1;
    pcIN   = pc;
    tick();
    loadIR = 1'b0;
  endtask

  task automatic arm();
    trcARM = 1'b1;
    tick();
    trcARM = 1'b0;
  endtask

  task automatic halt();
    cpuHALT = 1'b1;
    tick();
    cpuHALT = 1'b0;
  endtask

  task automatic rd(input bit expect_ack, input logic [35:0] exp);
    if (expect_ack) exp_q.push_back(exp);
    con.rdREQ = 1'b1;
    tick();
    con.rdREQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    con.rdREQ = 1'b0;
    repeat (3) tick();
    check("rst_ack",   {35'b0, con.rdACK}, 36'd0);
    check("rst_count", {31'b0, con.trcCOUNT}, 36'd0);
    check("rst_state", {34'b0, con.trcSTATE}, 36'd0);
    check("rst_data",  con.rdDATA, 36'd0);
    #2 rst = 1'b1;
    tick();

    // 1: simple fill, halt, read out oldest-first, then an empty read
    arm();
    check("t1_armed", {34'b0, con.trcSTATE}, 36'd1);
    for (int i = 0; i < 5; i++) capture(18'o1000 + 18'(i));
    check("t1_count5", {31'b0, con.trcCOUNT}, 36'd5);
    halt();
    check("t1_frozen", {34'b0, con.trcSTATE}, 36'd3);
    for (int i = 0; i < 5; i++) rd(1'b1, {18'b0, 18'o1000 + 18'(i)});
    rd(1'b1, 36'd0);
    tick();
    check("t1_count0", {31'b0, con.trcCOUNT}, 36'd0);

    // 2: wrap, oldest four overwritten
    arm();
    for (int i = 0; i < 20; i++) capture(18'(i));
    check("t2_count16", {31'b0, con.trcCOUNT}, 36'd16);
    halt();
    for (int i = 4; i < 20; i++) rd(1'b1, {18'b0, 18'(i)});
    tick();

    // 3: breakpoint at 030057, four more captures, then frozen
    brkADDR = 18'o030057;
    brkEN   = 1'b1;
    arm();
    for (int i = 0; i < 32; i++) capture(18'o030040 + 18'(i));
    check("t3_frozen", {34'b0, con.trcSTATE}, 36'd3);
    check("t3_count16", {31'b0, con.trcCOUNT}, 36'd16);
    for (int i = 0; i < 16; i++) rd(1'b1, {18'b0, 18'o030044 + 18'(i)});
    brkEN = 1'b0;
    tick();

    // 4: reads ignored while armed; clear dominates arm
    arm();
    capture(18'o7);
    capture(18'o17);
    capture(18'o27);
    rd(1'b0, 36'd0);
    tick();
    check("t4_count3", {31'b0, con.trcCOUNT}, 36'd3);
    check("t4_armed", {34'b0, con.trcSTATE}, 36'd1);
    trcCLR = 1'b1;
    trcARM = 1'b1;
    con.rdREQ = 1'b1;
    tick();
    trcCLR = 1'b0;
    trcARM = 1'b0;
    con.rdREQ = 1'b0;
    check("t4_idle", {34'b0, con.trcSTATE}, 36'd0);
    check("t4_flush", {31'b0, con.trcCOUNT}, 36'd0);
    rd(1'b1, 36'd0);
    tick();

    // 5: asynchronous reset in the middle of a readout
    arm();
    for (int i = 0; i < 4; i++) capture(18'o500 + 18'(i));
    halt();
    rd(1'b1, {18'b0, 18'o500});
    tick();
    con.rdREQ = 1'b1;
    @(posedge clk);
    #1;
    con.rdREQ = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_ack", {35'b0, con.rdACK}, 36'd0);
    check("t5_count", {31'b0, con.trcCOUNT}, 36'd0);
    check("t5_state", {34'b0, con.trcSTATE}, 36'd0);
    check("t5_data", con.rdDATA, 36'd0);
    #2 rst = 1'b1;
    tick();

    // 6: stamps of two captures ten clken cycles apart
    arm();
    capture(18'o111);
    repeat (9) tick();
    capture(18'o222);
    halt();
    rd_hist.delete();
    rd(1'b1, {18'b0, 18'o111});
    rd(1'b1, {18'b0, 18'o222});
    repeat (2) tick();
`ifdef DBG_TRACE_STAMP_EN
    if (rd_hist.size() == 2)
      check("t6_stamp_diff", {18'b0, rd_hist[1][35:18] - rd_hist[0][35:18]}, {18'b0, 18'o12});
    else
      check("t6_hist_len", 36'(rd_hist.size()), 36'd2);
`endif

    repeat (3) tick();
    check("sb_drained", 36'(exp_q.size()), 36'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
